// File: rtl/prememory_stage.sv
// Pre-memory pipeline stage: issues one data-SRAM request per memory op and registers the returned word.
// Optional build macro PM_ADDR_CHECK_EN enables misaligned-address detection (pm_ade).
module prememory_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] exe_pc,
   input  logic [31:0] exe_inst,
   input  logic [19:0] exe_out_op,
   input  logic [4:0]  exe_dest,
   input  logic [31:0] exe_value,
   input  logic [31:0] exe_st_value,
   input  logic        exe_to_pm_valid,
   output logic        pm_allowin,
   output logic [31:0] pm_pc,
   output logic [31:0] pm_inst,
   output logic [19:0] pm_out_op,
   output logic [4:0]  pm_dest,
   output logic [31:0] pm_value,
   output logic [31:0] pm_ld_value,
   output logic [31:0] pm_rdata,
   output logic        pm_valid,
   output logic        pm_to_mem_valid,
   input  logic        mem_allowin,
   output logic        data_req,
   output logic        data_wr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   input  logic        ctrl_pm_disable,
   output logic        pm_ade
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

   state_t      state;
   logic        pm_ready_go;
   logic        entering;
   logic        exe_mem_op;
   logic        ade_next;
   logic [2:0]  exe_ld_type;
   logic [2:0]  exe_st_type;
   logic [2:0]  st_type;
   logic [1:0]  a;
   logic [31:0] rt;

   assign exe_ld_type = exe_out_op[6:4];
   assign exe_st_type = exe_out_op[9:7];
   assign exe_mem_op  = (exe_ld_type != 3'b000) || (exe_st_type != 3'b000);
   assign st_type     = pm_out_op[9:7];
   assign a           = pm_value[1:0];
   assign rt          = pm_ld_value;

   assign pm_ready_go     = pm_valid && (state == S_IDLE || state == S_DONE);
   assign pm_allowin      = (!pm_valid || (pm_ready_go && mem_allowin))
                            && (state != S_CANCEL) && (state != S_WAIT);
   assign pm_to_mem_valid = pm_ready_go && !ctrl_pm_disable;
   assign entering        = exe_to_pm_valid && pm_allowin;

   assign data_req  = (state == S_REQ);
   assign data_wr   = (st_type != 3'b000);
   assign data_addr = {pm_value[31:2], 2'b00};

`ifdef PM_ADDR_CHECK_EN
   always_comb begin
      ade_next = 1'b0;
      if ((exe_ld_type == 3'b001 || exe_st_type == 3'b001) && exe_value[1:0] != 2'b00)
         ade_next = 1'b1;
      if ((exe_ld_type == 3'b101 || exe_ld_type == 3'b111 || exe_st_type == 3'b101) && exe_value[0])
         ade_next = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         pm_ade <= 1'b0;
      else if (entering)
         pm_ade <= ade_next;
   end
`else
   assign ade_next = 1'b0;
   assign pm_ade   = 1'b0;
`endif

   // Store lane selection from the low address bits; loads leave all strobes clear.
   always_comb begin
      data_wstrb = 4'b0000;
      data_wdata = '0;
      case (st_type)
         3'b001: begin
            data_wstrb = 4'b1111;
            data_wdata = rt;
         end
         3'b010: begin
            case (a)
               2'd0: begin data_wstrb = 4'b0001; data_wdata = {24'b0, rt[31:24]}; end
               2'd1: begin data_wstrb = 4'b0011; data_wdata = {16'b0, rt[31:16]}; end
               2'd2: begin data_wstrb = 4'b0111; data_wdata = {8'b0, rt[31:8]};   end
               default: begin data_wstrb = 4'b1111; data_wdata = rt; end
            endcase
         end
         3'b011: begin
            case (a)
               2'd0: begin data_wstrb = 4'b1111; data_wdata = rt; end
               2'd1: begin data_wstrb = 4'b1110; data_wdata = {rt[23:0], 8'b0};  end
               2'd2: begin data_wstrb = 4'b1100; data_wdata = {rt[15:0], 16'b0}; end
               default: begin data_wstrb = 4'b1000; data_wdata = {rt[7:0], 24'b0}; end
            endcase
         end
         3'b100: begin
            data_wstrb = 4'b0001 << a;
            data_wdata = {4{rt[7:0]}};
         end
         3'b101: begin
            data_wstrb = a[1] ? 4'b1100 : 4'b0011;
            data_wdata = {2{rt[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         pm_valid    <= 1'b0;
         pm_pc       <= 32'hbfc00000;
         pm_inst     <= '0;
         pm_out_op   <= '0;
         pm_dest     <= '0;
         pm_value    <= '0;
         pm_ld_value <= '0;
         pm_rdata    <= '0;
      end else begin
         if (pm_allowin)
            pm_valid <= exe_to_pm_valid;

         if (entering) begin
            pm_pc       <= exe_pc;
            pm_inst     <= exe_inst;
            pm_out_op   <= exe_out_op;
            pm_dest     <= exe_dest;
            pm_value    <= exe_value;
            pm_ld_value <= exe_st_value;
            state       <= (exe_mem_op && !ade_next) ? S_REQ : S_IDLE;
         end else begin
            case (state)
               S_REQ: begin
                  // An accepted address means a response is still owed; CANCEL absorbs it.
                  if (ctrl_pm_disable) begin
                     pm_valid <= 1'b0;
                     state    <= data_addr_ok ? S_CANCEL : S_IDLE;
                  end else if (data_addr_ok) begin
                     state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (data_data_ok) begin
                     pm_rdata <= data_rdata;
                     if (ctrl_pm_disable) begin
                        pm_valid <= 1'b0;
                        state    <= S_IDLE;
                     end else begin
                        state <= S_DONE;
                     end
                  end else if (ctrl_pm_disable) begin
                     pm_valid <= 1'b0;
                     state    <= S_CANCEL;
                  end
               end
               S_CANCEL: begin
                  if (data_data_ok)
                     state <= S_IDLE;
               end
               default: begin
                  if (ctrl_pm_disable)
                     pm_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
